// File: rtl/oam_dma.sv
// OAM DMA engine behind FF46: copies LEN bytes from {src_hi,00..} into OAM, one byte per M-cycle.
// Optional CPU bus blocking during a transfer is enabled by defining OAM_DMA_CPU_BLOCK_EN.
module oam_dma #(
  parameter int LEN         = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        reg_write,
  input  logic [7:0]  reg_d_wr,
  output logic [7:0]  reg_d_rd,
  input  logic [15:0] cpu_addr,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_d_in,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_d_wr,
  output logic        oam_write,
  output logic        cpu_blocked
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

  logic [1:0] state;
  logic [7:0] idx;
  logic [7:0] dly_cnt;
  logic [7:0] src_hi;
  logic [7:0] reg_q;

  // Sources in echo RAM (E000-FDFF) alias onto work RAM (C000-DDFF).
  function automatic logic [7:0] fold_src(input logic [7:0] v);
    fold_src = (v >= 8'hE0) ? (v & 8'hDF) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 8'h00;
      dly_cnt <= 8'h00;
      src_hi  <= 8'h00;
      reg_q   <= 8'hFF;
    end else if (ce) begin
      if (reg_write) begin
        reg_q   <= reg_d_wr;
        src_hi  <= fold_src(reg_d_wr);
        idx     <= 8'h00;
        dly_cnt <= 8'h00;
        state   <= S_START;
      end else begin
        case (state)
          S_IDLE: ;
          S_START: begin
            if (dly_cnt == DLY_LAST) begin
              dly_cnt <= 8'h00;
              state   <= S_XFER;
            end else begin
              dly_cnt <= dly_cnt + 8'h01;
            end
          end
          // idx parks on the final byte so dma_addr keeps showing the last source in IDLE.
          S_XFER: begin
            if (idx == LAST_IDX) begin
              state <= S_IDLE;
            end else begin
              idx <= idx + 8'h01;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // A restart write on an XFER edge takes priority over that edge's copy.
  assign oam_write  = ce & ~rst & ~reg_write & (state == S_XFER);
  assign oam_addr   = idx;
  assign oam_d_wr   = dma_d_in;
  assign dma_addr   = {src_hi, idx};
  assign dma_active = (state != S_IDLE);
  assign reg_d_rd   = reg_q;

`ifdef OAM_DMA_CPU_BLOCK_EN
  // HRAM (FF80-FFFF) stays reachable so the CPU can run its wait loop there.
  assign cpu_blocked = dma_active & (cpu_addr[15:7] != 9'h1FF);
`else
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^cpu_addr;
  assign cpu_blocked     = 1'b0;
`endif

endmodule
